// File: rtl/div_pkg.sv
// Shared definitions for the serial divider.
// Contents:
//   div_state_e - controller state encoding (IDLE, CALC, FIX, DONE)
//   bpc_legal() - returns 1 when a DATA_W/BPC pair is supported
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Legal configurations:
    //   - BPC is 1, 2 or 4 and divides DATA_W evenly.
    //   - DATA_W is even and at least 8.
    function automatic bit bpc_legal(input int data_w, input int bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
               ((data_w % bpc) == 0) &&
               ((data_w % 2) == 0) && (data_w >= 8);
    endfunction

endpackage

// File: rtl/div_rx_step.sv
// One combinational iteration block of the restoring divider: retires BPC
// quotient bits per use.
// Ports:
//   rem_i      - partial remainder before this step (DATA_W+1 bits)
//   dvd_bits_i - next BPC dividend bits, MSB first
//   dvs_i      - divisor magnitude
//   rem_o      - partial remainder after BPC iterations
//   q_o        - the BPC quotient bits produced, MSB first
module div_rx_step
    import div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BPC    = 2
) (
    input  logic [DATA_W:0]   rem_i,
    input  logic [BPC-1:0]    dvd_bits_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W:0]   rem_o,
    output logic [BPC-1:0]    q_o
);

    logic [DATA_W:0]   rem;
    logic [DATA_W+1:0] trial;

    // The partial remainder stays below the divisor, so each shifted trial
    // value fits in DATA_W+2 bits. A trial that is not less than the
    // divisor keeps the difference; otherwise the shifted value is restored.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch;
        // otherwise the combinational block would infer a latch.
        rem   = rem_i;
        trial = '0;
        q_o   = '0;
        for (int i = 0; i < BPC; i++) begin
            trial = {rem, dvd_bits_i[BPC-1-i]};
            if (trial >= {2'b00, dvs_i}) begin
                rem            = (DATA_W+1)'(trial - {2'b00, dvs_i});
                q_o[BPC-1-i]   = 1'b1;
            end else begin
                rem = trial[DATA_W:0];
            end
        end
        rem_o = rem;
    end

endmodule

// File: rtl/div_serial_rx.sv
// Iterative signed/unsigned divider with valid/ready handshakes on both sides.
// Uses restoring shift-subtract on operand magnitudes and retires BPC
// quotient bits per cycle. A final cycle applies the sign correction.
// The latency is fixed: out_valid rises N+1 edges after the accept edge,
// where N = DATA_W/BPC.
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   in_valid, in_ready   - operand handshake (in_ready high only in IDLE)
//   sign                 - 1 = two's-complement operands, 0 = unsigned
//   dividend, divisor    - operands
//   out_valid, out_ready - result handshake (out_valid high only in DONE)
//   quotient, remainder  - results; held while out_valid && !out_ready
//   dbz, ovf             - divide-by-zero flag; signed MIN/-1 overflow flag
module div_serial_rx
    import div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BPC    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              dbz,
    output logic              ovf
);

    localparam int                N        = DATA_W / BPC;
    localparam int                CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
    localparam logic [DATA_W-1:0] SMIN     = {1'b1, {(DATA_W-1){1'b0}}};

    if (!bpc_legal(DATA_W, BPC)) begin : g_bad_cfg
        $error("div_serial_rx: unsupported DATA_W/BPC combination");
    end

    div_state_e        state_q, state_d;
    logic [DATA_W:0]   rem_q, rem_d;     // partial remainder, then final remainder
    logic [DATA_W-1:0] dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
    logic [DATA_W-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              qneg_q, qneg_d;   // negate quotient in FIX
    logic              rneg_q, rneg_d;   // negate remainder in FIX
    logic              dbz_q, dbz_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W:0]   step_rem;
    logic [BPC-1:0]    step_q;
    logic              a_neg, b_neg;

    div_rx_step #(
        .DATA_W (DATA_W),
        .BPC    (BPC)
    ) u_step (
        .rem_i      (rem_q),
        .dvd_bits_i (dvd_q[DATA_W-1 -: BPC]),
        .dvs_i      (dvs_q),
        .rem_o      (step_rem),
        .q_o        (step_q)
    );

    assign a_neg = sign & dividend[DATA_W-1];
    assign b_neg = sign & divisor[DATA_W-1];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = '0;
                    dvd_d   = a_neg ? -dividend : dividend;
                    dvs_d   = b_neg ? -divisor : divisor;
                    cnt_d   = '0;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dbz_d   = (divisor == '0);
                    ovf_d   = sign && (dividend == SMIN) && (divisor == '1);
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[DATA_W-BPC-1:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // A zero divisor leaves the remainder magnitude equal to
                // |dividend|. The dividend-sign correction then restores the
                // original dividend, so only the quotient needs an override.
                // For MIN/-1 the plain correction already yields MIN rem 0.
                dvd_d   = dbz_q  ? '1 : (qneg_q ? -dvd_q : dvd_q);
                rem_d   = {1'b0, rneg_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0]};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the values from before this edge, whatever the statement order.
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = dvd_q;
    assign remainder = rem_q[DATA_W-1:0];
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_serial_rx.sv
// Self-checking bench for div_serial_rx. Three instances (BPC = 1, 2, 4, all
// DATA_W = 32) share the operand inputs and each has its own out_ready.
// Expected results come from directed constants or from an arithmetic
// reference model (SV integer division, which truncates toward zero).
module tb_div_serial_rx;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              sign;
    logic [31:0]       dividend;
    logic [31:0]       divisor;
    logic [2:0]        in_ready;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [2:0][31:0]  quotient;
    logic [2:0][31:0]  remainder;
    logic [2:0]        dbz;
    logic [2:0]        ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        div_serial_rx #(
            .DATA_W (32),
            .BPC    (1 << g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .sign      (sign),
            .dividend  (dividend),
            .divisor   (divisor),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .quotient  (quotient[g]),
            .remainder (remainder[g]),
            .dbz       (dbz[g]),
            .ovf       (ovf[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: special cases first, then plain integer division.
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic f_dbz, output logic f_ovf);
        int sa, sb;
        f_dbz = 1'b0;
        f_ovf = 1'b0;
        if (b == 32'd0) begin
            q     = 32'hFFFF_FFFF;
            r     = a;
            f_dbz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q     = a;
            r     = 32'd0;
            f_ovf = 1'b1;
        end else if (s) begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issues one operation to all three instances, then follows each one to
    // its handshake. Checks:
    //   - the exact out_valid latency (N+1 edges);
    //   - the results on every cycle out_valid is high (so they must hold
    //     while stalled);
    //   - all instances are idle the cycle after the last handshake.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic ed, input logic eo, input bit rnd, input string name);
        bit [2:0] done;
        bit [2:0] seen;
        @(negedge clk);
        sign     = s;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        check({name, " in_ready idle"}, 32'(in_ready), 32'h7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sign     = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor  = $urandom;
        done = '0;
        seen = '0;
        for (int cyc = 1; cyc <= 400 && done != 3'b111; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!done[d] && out_valid[d]) begin
                    if (!seen[d]) begin
                        seen[d] = 1'b1;
                        check({name, " latency"}, 32'(cyc), 32'(32 / (1 << d) + 1));
                    end
                    check({name, " quotient"}, quotient[d], eq);
                    check({name, " remainder"}, remainder[d], er);
                    check({name, " dbz/ovf"}, 32'({dbz[d], ovf[d]}), 32'({ed, eo}));
                    check({name, " in_ready busy"}, 32'(in_ready[d]), 32'd0);
                    out_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (out_ready[d]) done[d] = 1'b1;
                end
            end
        end
        check({name, " completion"}, 32'(done), 32'h7);
        @(posedge clk);
        @(negedge clk);
        check({name, " idle after handshake"}, 32'({in_ready, out_valid}), 32'h38);
    endtask

    initial begin
        logic        s;
        logic [31:0] a, b, eq, er;
        logic        ed, eo;
        bit [2:0]    saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        sign      = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 3'b111;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready/out_valid", 32'({in_ready, out_valid}), 32'h38);
        check("reset flags", 32'({dbz, ovf}), 32'd0);
        for (int d = 0; d < 3; d++) begin
            check("reset quotient", quotient[d], 32'd0);
            check("reset remainder", remainder[d], 32'd0);
        end
        rst = 1'b0;

        // Directed cases.
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, "u 100/7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "s -7/2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 1'b0, "s 7/-2");
        run_op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1'b0, "u dbz");
        run_op(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1'b0, "s dbz");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, "s MIN/-1");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, "u MIN/-1");

        // Backpressure: results hold and new requests are ignored while stalled.
        @(negedge clk);
        out_ready = 3'b000;
        sign      = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd33;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 60 && out_valid != 3'b111; cyc++) @(negedge clk);
        check("bp all valid", 32'(out_valid), 32'h7);
        for (int k = 0; k < 5; k++) begin
            sign     = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            in_valid = 1'b1;
            check("bp in_ready low", 32'(in_ready), 32'd0);
            check("bp out_valid held", 32'(out_valid), 32'h7);
            for (int d = 0; d < 3; d++) begin
                check("bp quotient stable", quotient[d], 32'd30);
                check("bp remainder stable", remainder[d], 32'd10);
            end
            @(negedge clk);
        end
        out_ready = 3'b111;
        @(posedge clk);
        @(negedge clk);
        check("bp idle after exit edge", 32'({in_ready, out_valid}), 32'h38);
        in_valid = 1'b0;

        // Reset during the 5th CALC cycle discards the operation.
        @(negedge clk);
        sign     = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst in_ready/out_valid", 32'({in_ready, out_valid}), 32'h38);
        check("rst flags", 32'({dbz, ovf}), 32'd0);
        for (int d = 0; d < 3; d++) begin
            check("rst quotient", quotient[d], 32'd0);
            check("rst remainder", remainder[d], 32'd0);
        end
        saw_valid = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            saw_valid |= out_valid;
        end
        check("rst no result", 32'(saw_valid), 32'd0);

        // Random sweep with random backpressure.
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3:    b = $urandom_range(1, 15);
                4:       b = -($urandom_range(1, 255));
                5:       b = a;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(s, a, b, eq, er, ed, eo);
            run_op(s, a, b, eq, er, ed, eo, 1'b1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
